// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher: fetches one background line of tile pixels from VRAM.
// For each group of four tiles, one name-table word is read. Then one
// pattern word is read per tile, and a 16-bit slice of it (8 pixels at
// 2 bpp) is written into the line buffer.
// Optional feature: define BG_FETCHER_HFLIP_EN to use name-byte bit 7 as a
// per-tile horizontal flip. The tile index is then limited to bits 6:0.
module bg_line_fetcher #(
  parameter int ADDR_BITS    = 11,
  parameter int TILES        = 40,
  parameter int LINES        = 200,
  parameter int PATTERN_BASE = 0,
  parameter int NAME_BASE    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           line,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] vram_addr,
  output logic [31:0]          vram_d,
  output logic                 vram_we,
  input  logic [31:0]          vram_q,
  output logic                 lb_we,
  output logic [5:0]           lb_addr,
  output logic [15:0]          lb_data
);

  typedef enum logic [2:0] {
    IDLE,
    NAME_RD,
    NAME_LAT,
    PAT_RD,
    PAT_LAT,
    DONE
  } state_t;

  localparam logic [5:0] LAST_TILE = 6'(TILES - 1);

  state_t      state;
  logic [5:0]  tile;
  logic [7:0]  line_r;
  logic [31:0] name_r;
  logic [5:0]  tile_next;

  // This port never writes VRAM.
  assign vram_d  = '0;
  assign vram_we = 1'b0;

  assign tile_next = tile + 6'd1;

  // Name-table word holding the entries for four consecutive tiles.
  function automatic logic [ADDR_BITS-1:0] name_addr(input logic [7:0] ln,
                                                     input logic [5:0] t);
    logic [31:0] a;
    a = 32'(NAME_BASE) + 32'(ln[7:3]) * 32'(TILES / 4) + 32'(t[5:2]);
    return a[ADDR_BITS-1:0];
  endfunction

  // Pattern word: 4 words per tile, each holding two pixel rows.
  function automatic logic [ADDR_BITS-1:0] pat_addr(input logic [7:0] idx,
                                                    input logic [7:0] ln);
    logic [31:0] a;
    a = 32'(PATTERN_BASE) + 32'(idx) * 32'd4 + 32'(ln[2:1]);
    return a[ADDR_BITS-1:0];
  endfunction

  // Byte 0 of a name word (bits 31:24) belongs to the lowest tile of the group.
  function automatic logic [7:0] name_byte(input logic [31:0] w,
                                           input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] tile_idx(input logic [31:0] w,
                                          input logic [1:0]  sel);
    logic [7:0] b;
    b = name_byte(w, sel);
`ifdef BG_FETCHER_HFLIP_EN
    return {1'b0, b[6:0]};
`else
    return b;
`endif
  endfunction

  // Fetch sequencer; all outputs except lb_data are registered here.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      vram_addr <= '0;
      tile      <= '0;
      line_r    <= '0;
      name_r    <= '0;
    end else begin
      done  <= 1'b0;
      lb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (int'(line) >= LINES) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              line_r    <= line;
              tile      <= '0;
              busy      <= 1'b1;
              vram_addr <= name_addr(line, 6'd0);
              state     <= NAME_RD;
            end
          end
        end
        NAME_RD: state <= NAME_LAT;
        NAME_LAT: begin
          // The name word is on vram_q now, so the first pattern address is
          // formed straight from it, in the same cycle that name_r loads.
          name_r    <= vram_q;
          vram_addr <= pat_addr(tile_idx(vram_q, tile[1:0]), line_r);
          state     <= PAT_RD;
        end
        PAT_RD: begin
          lb_we   <= 1'b1;
          lb_addr <= tile;
          state   <= PAT_LAT;
        end
        PAT_LAT: begin
          tile <= tile_next;
          if (tile == LAST_TILE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (tile_next[1:0] == 2'd0) begin
            vram_addr <= name_addr(line_r, tile_next);
            state     <= NAME_RD;
          end else begin
            vram_addr <= pat_addr(tile_idx(name_r, tile_next[1:0]), line_r);
            state     <= PAT_RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel data comes straight from vram_q during PAT_LAT (lb_we high).
  // The gate by lb_we keeps it at 0 in every other cycle and under reset.
  always_comb begin
    logic [15:0] half;
`ifdef BG_FETCHER_HFLIP_EN
    logic [7:0]  cur_byte;
    logic [15:0] rev;
`endif
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    half    = line_r[0] ? vram_q[15:0] : vram_q[31:16];
    lb_data = '0;
`ifdef BG_FETCHER_HFLIP_EN
    cur_byte = name_byte(name_r, tile[1:0]);
    rev      = '0;
    for (int p = 0; p < 8; p++) begin
      rev[2*p +: 2] = half[14-2*p +: 2];
    end
    if (lb_we) begin
      lb_data = cur_byte[7] ? rev : half;
    end
`else
    if (lb_we) begin
      lb_data = half;
    end
`endif
  end

endmodule

// File: doc/bg_line_fetcher.md
BG_LINE_FETCHER -- requirements
Module: bg_line_fetcher

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- ADDR_BITS, 11, VRAM word address width.
- TILES, 40, tiles per line; multiple of 4, at most 64.
- LINES, 200, visible lines.
- PATTERN_BASE, 0, word address of the pattern table.
- NAME_BASE, 1024, word address of the name table.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle request to fetch a line.
- line, in, 8, pixel line number, sampled with start.
- busy, out, 1, fetch in progress.
- done, out, 1, one-cycle completion pulse.
- vram_addr, out, ADDR_BITS, VRAM GPU-port address (registered).
- vram_d, out, 32, VRAM write data; tied 0.
- vram_we, out, 1, VRAM write enable; tied 0.
- vram_q, in, 32, VRAM read data; valid the cycle after vram_addr is presented.
- lb_we, out, 1, line-buffer write strobe.
- lb_addr, out, 6, tile slot 0..TILES-1.
- lb_data, out, 16, 8 pixels at 2 bpp; pixel 0 in bits 15:14.

Function
REQ-003 SHALL implement states IDLE, NAME_RD, NAME_LAT, PAT_RD, PAT_LAT, DONE.
REQ-004 In IDLE, start=1 SHALL latch line, set tile=0, assert busy and go to NAME_RD, unless line>=LINES; in that case it SHALL go directly to DONE and issue no lb_we.
REQ-005 NAME_RD SHALL drive vram_addr = NAME_BASE + (line>>3)*(TILES/4) + (tile>>2), truncated to ADDR_BITS, then go to NAME_LAT.
REQ-006 NAME_LAT SHALL capture vram_q into the name register, then go to PAT_RD.
REQ-007 The tile index SHALL be the name-register byte selected by tile[1:0]; byte 0 is bits 31:24 and byte 3 is bits 7:0.
REQ-008 PAT_RD SHALL drive vram_addr = PAT_BASE + idx*4 + line[2:1], truncated to ADDR_BITS, then go to PAT_LAT.
REQ-009 PAT_LAT SHALL pulse lb_we for one cycle with:
- lb_addr = tile.
- lb_data = vram_q[31:16] when line[0]=0, else vram_q[15:0].
REQ-010 After PAT_LAT, tile SHALL increment and the next state SHALL be:
- DONE if tile was TILES-1;
- NAME_RD if the new tile[1:0]=0;
- PAT_RD otherwise.
REQ-011 DONE SHALL pulse done for exactly one cycle, deassert busy on the same cycle, and return to IDLE.
REQ-012 Timing SHALL be:
- 2 cycles per name fetch and 2 cycles per tile, giving 10 cycles per 4 tiles.
- done SHALL assert exactly 10*TILES/4 + 1 cycles after the start cycle; this is 101 cycles at defaults.
REQ-013 start SHALL be ignored while busy=1 or in the DONE cycle; no queuing.
REQ-014 When not in NAME_RD or PAT_RD, vram_addr SHALL hold its last value.
REQ-015 lb_we SHALL be asserted only in PAT_LAT.

Reset
REQ-016 reset=1 SHALL, immediately and asynchronously, force:
- state to IDLE;
- busy, done, lb_we, lb_addr, lb_data, vram_addr and tile to 0.
REQ-017 A reset mid-fetch SHALL abort the fetch with no further lb_we and no done pulse; the first start after reset release SHALL behave per REQ-004.

Configuration
REQ-018 Macro BG_FETCHER_HFLIP_EN SHALL control horizontal flip.
REQ-019 With BG_FETCHER_HFLIP_EN defined:
- idx SHALL be name byte bits 6:0.
- Bit 7 = 1 SHALL reverse the pixel order of lb_data (the 2-bit pairs reversed, bits within each pair unchanged).
REQ-020 Without BG_FETCHER_HFLIP_EN, idx SHALL be the full 8-bit byte and lb_data SHALL be unmodified.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic fetch: start with line=0, NAME_BASE word 0=0x01020304, pattern tile 1 word 0=0xABCD1234 -> first lb_we has lb_addr=0, lb_data=0xABCD; done pulses 101 cycles after start; exactly 40 lb_we pulses.
- Odd row select: line=9, pattern word line[2:1]=0 holding 0x5555AAAA -> vram_addr of the first name read = 1034; lb_data=0xAAAA.
- Out-of-range line: start with line=200 -> done 1 cycle later; zero lb_we; vram_addr unchanged.
- Start while busy: start pulse at cycle 50 of a fetch -> ignored; done still at cycle 101; next start accepted only after done.
- Reset mid-fetch: reset at cycle 30 -> busy, done and lb_we all 0 immediately; no done; a new start with line=8 completes in 101 cycles.
- Flip (macro defined): name byte 0x81, pattern halfword 0x1B00 -> lb_data=0x00E4; macro undefined -> idx=0x81 is used and lb_data is unflipped.
